reduce_pool: RTL and testbench

- Parametrised column-reduction engine, next generation of the fixed 16x16 int8 column-mean block in the feature-extraction path.
- Reduces each column of a signed ROWS x COLS matrix to one DW-bit value, one element per cycle.
- Selectable mode: mean, saturating sum or max.
- Start/done handshake with a busy flag; `enable` no longer has to be held.

---
 rtl/reduce_pkg.sv | 28 ++
 rtl/reduce_acc.sv | 51 +++++
 rtl/reduce_pool.sv | 114 +++++++++++
 tb/tb_reduce_pool.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared types and helpers for the reduce_pool column-reduction engine.
package reduce_pkg;

    typedef enum logic [1:0] {
        MEAN    = 2'b00,
        SUM_SAT = 2'b01,
        MAX     = 2'b10
    } reduce_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACC   = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } reduce_state_t;

    // Clamp a signed value to the range of a dw-bit signed number.
    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/reduce_acc.sv
// Column accumulator: loads/combines one element per enabled cycle and
// presents the mode-dependent finalised DW-bit result.
module reduce_acc
    import reduce_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  reduce_mode_t         mode,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] result
);

    localparam int SH = $clog2(ROWS);
    localparam int AW = DW + SH;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] din_x;

    assign din_x = AW'(din);

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = din_x;
        end else if (en) begin
            if (mode == MAX) acc_d = (din_x > acc_q) ? din_x : acc_q;
            else             acc_d = acc_q + din_x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    // AW leaves enough headroom that the sum never wraps before finalising.
    always_comb begin
        case (mode)
            MAX:     result = DW'(acc_q);
            SUM_SAT: result = DW'(sat_dw(32'(acc_q), DW));
            default: result = DW'(acc_q >>> SH);
        endcase
    end

endmodule

// File: rtl/reduce_pool.sv
// Column-reduction engine: one element per cycle, one WRITE per column,
// results held in a register bank until overwritten or reset.
module reduce_pool
    import reduce_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic signed [DW-1:0] matrix_in  [ROWS][COLS],
    output logic signed [DW-1:0] matrix_out [COLS],
    output logic                 busy,
    output logic                 done,
    output reduce_state_t        dbg_state_o
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    reduce_state_t state_q, state_d;
    reduce_mode_t  mode_q, mode_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          acc_load;
    logic          acc_en;
    logic          wr_en;
    logic signed [DW-1:0] elem;
    logic signed [DW-1:0] acc_result;

    // Handshake: start is a single-cycle request honoured only in IDLE; busy
    // covers every ACC/WRITE cycle, done pulses once afterwards, and the
    // producer keeps matrix_in stable while busy is high.
    assign busy        = (state_q == ACC) || (state_q == WRITE);
    assign done        = (state_q == DONE);
    assign dbg_state_o = state_q;
    assign elem        = matrix_in[row_q][col_q];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        acc_load = 1'b0;
        acc_en   = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    row_d   = '0;
                    col_d   = '0;
                    mode_d  = (mode == 2'b11) ? MEAN : reduce_mode_t'(mode);
                end
            end
            ACC: begin
                acc_en   = 1'b1;
                acc_load = (row_q == '0);
                if (row_q == RW'(ROWS - 1)) state_d = WRITE;
                else                        row_d   = row_q + RW'(1);
            end
            WRITE: begin
                wr_en = 1'b1;
                row_d = '0;
                if (col_q == CW'(COLS - 1)) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q + CW'(1);
                    state_d = ACC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MEAN;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COLS; i++) matrix_out[i] <= '0;
        end else if (wr_en) begin
            matrix_out[col_q] <= acc_result;
        end
    end

    reduce_acc #(
        .ROWS (ROWS),
        .DW   (DW)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .load   (acc_load),
        .en     (acc_en),
        .mode   (mode_q),
        .din    (elem),
        .result (acc_result)
    );

endmodule

// File: tb/tb_reduce_pool.sv
// Bench for reduce_pool: default 16x16x8 instance plus a 4x8x6 instance,
// checked against a plain-arithmetic column reduction model.
module tb_reduce_pool;
    import reduce_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start, start_s;
    logic [1:0] mode, mode_s;
    logic signed [7:0] mat  [16][16];
    logic signed [7:0] mout [16];
    logic busy, done;
    reduce_state_t st, st_s;
    logic signed [5:0] mat_s  [4][8];
    logic signed [5:0] mout_s [8];
    logic busy_s, done_s;

    int checks = 0;
    int failures = 0;
    int busy_first, busy_last, busy_cnt, done_cyc, done_cnt;
    int prev_exp [16];
    logic signed [15:0] exp_q [$];

    always #5 clk = ~clk;

    reduce_pool #(.ROWS(16), .COLS(16), .DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .matrix_in(mat),
        .matrix_out(mout), .busy(busy), .done(done), .dbg_state_o(st)
    );

    reduce_pool #(.ROWS(4), .COLS(8), .DW(6)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .mode(mode_s), .matrix_in(mat_s),
        .matrix_out(mout_s), .busy(busy_s), .done(done_s), .dbg_state_o(st_s)
    );

    // Reduction model: mean is the floored quotient, sum clamps, max picks largest.
    function automatic int ref_reduce(input int vals[$], input int md, input int dw);
        int s, mx, lo, hi, n, q;
        n  = vals.size();
        s  = 0;
        mx = vals[0];
        lo = -(1 << (dw - 1));
        hi = (1 << (dw - 1)) - 1;
        foreach (vals[i]) begin
            s += vals[i];
            if (vals[i] > mx) mx = vals[i];
        end
        case (md)
            1: return (s < lo) ? lo : ((s > hi) ? hi : s);
            2: return mx;
            default: begin
                q = s / n;
                if ((q * n != s) && (s < 0)) q = q - 1;
                return q;
            end
        endcase
    endfunction

    function automatic int ref_col(input int c, input int md);
        int vals[$];
        for (int r = 0; r < 16; r++) vals.push_back(int'(mat[r][c]));
        return ref_reduce(vals, md, 8);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic fill_random(input int span);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mat[r][c] = 8'($urandom_range(0, 2 * span - 1) - span);
    endtask

    // Drive one start and record busy/done cycle numbers relative to it.
    task automatic run_pass(input bit sel, input logic [1:0] md, input int glitch_at, input int max_cyc);
        logic b, d;
        busy_first = -1; busy_last = -1; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        @(negedge clk);
        if (sel) begin mode_s = md; start_s = 1'b1; end
        else     begin mode = md;   start = 1'b1;   end
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            start   = (!sel && k == glitch_at);
            if (!sel && k == glitch_at) mode = md ^ 2'b01;
            b = sel ? busy_s : busy;
            d = sel ? done_s : done;
            if (b === 1'b1) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
                busy_cnt++;
            end
            if (d === 1'b1) begin
                if (done_cyc < 0) done_cyc = k;
                done_cnt++;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_timing(input string tag, input int last, input int done_at);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"}, busy_last, last);
        check({tag, "_busy_cnt"}, busy_cnt, last);
        check({tag, "_done_cyc"}, done_cyc, done_at);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic check_cols(input string tag, input int md);
        logic signed [15:0] e;
        for (int c = 0; c < 16; c++) exp_q.push_back(16'(ref_col(c, md)));
        for (int c = 0; c < 16; c++) begin
            e = exp_q.pop_front();
            prev_exp[c] = int'(e);
            check($sformatf("%s_col%0d", tag, c), mout[c], e);
        end
    endtask

    task automatic check_reset(input string tag);
        int nz;
        nz = 0;
        for (int c = 0; c < 16; c++) if (mout[c] !== 8'sd0) nz++;
        check({tag, "_out_nonzero"}, nz, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int vals[$];
        rst = 1'b1; start = 1'b0; start_s = 1'b0; mode = 2'b00; mode_s = 2'b00;
        fill_random(128);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) mat_s[r][c] = 6'(c - 4);
        #12;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // all ones, MEAN, with an ignored start at cycle 50 that also changes mode
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mat[r][c] = 8'sd1;
        run_pass(1'b0, 2'b00, 50, 280);
        check_timing("ones", 272, 273);
        check_cols("mean_ones", 0);

        fill_random(128);
        for (int r = 0; r < 16; r++) begin
            mat[r][0] = (r == 15) ? 8'sd0 : 8'sd1;
            mat[r][1] = (r == 0) ? -8'sd1 : 8'sd0;
            mat[r][2] = -8'sd128;
        end
        run_pass(1'b0, 2'b00, 0, 280);
        check_cols("mean_floor", 0);

        fill_random(8);
        for (int r = 0; r < 16; r++) begin
            mat[r][0] = 8'sd127;
            mat[r][1] = -8'sd128;
            mat[r][2] = (r == 0) ? 8'sd10 : 8'sd6;
        end
        run_pass(1'b0, 2'b01, 0, 280);
        check_cols("sum_sat", 1);

        fill_random(128);
        for (int r = 0; r < 16; r++) begin
            mat[r][0] = (r == 9) ? -8'sd3 : -8'sd128;
            mat[r][1] = -8'sd7;
        end
        mat[0][2] = 8'sd127;
        run_pass(1'b0, 2'b10, 0, 280);
        check_cols("max", 2);

        fill_random(128);
        run_pass(1'b0, 2'b11, 0, 280);
        check_cols("mode11_mean", 0);

        // interrupted run: cols 0..4 written, later columns keep the previous run
        fill_random(128);
        run_pass(1'b0, 2'b10, 0, 99);
        for (int c = 0; c < 16; c++)
            check($sformatf("partial_col%0d", c), mout[c], (c < 5) ? ref_col(c, 2) : prev_exp[c]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        run_pass(1'b0, 2'b10, 0, 280);
        check_timing("after_rst", 272, 273);
        check_cols("after_rst_max", 2);

        // small geometry instance
        run_pass(1'b1, 2'b00, 0, 50);
        check_timing("small", 40, 41);
        for (int c = 0; c < 8; c++) begin
            vals.delete();
            for (int r = 0; r < 4; r++) vals.push_back(int'(mat_s[r][c]));
            exp_q.push_back(16'(ref_reduce(vals, 0, 6)));
        end
        for (int c = 0; c < 8; c++)
            check($sformatf("small_col%0d", c), mout_s[c], exp_q.pop_front());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
